// File: rtl/mmu_pkg.sv
// Shared MMU types and constants for the page-table walker and its
// data-memory side.
package mmu_pkg;

  localparam int SIZE_VADDR = 39;

  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [3:0] MT_D  = 4'b0011;

  typedef struct packed {
    logic                valid;
    logic                phys;
    logic [4:0]          cmd;
    logic [3:0]          typ;
    logic [SIZE_VADDR:0] addr;
    logic                kill;
    logic [63:0]         data;
  } ptw_dmem_req_t;

  typedef struct packed {
    ptw_dmem_req_t req;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic        valid;
    logic        nack;
    logic [63:0] data;
  } dmem_ptw_resp_t;

  typedef struct packed {
    logic           dmem_ready;
    dmem_ptw_resp_t resp;
  } dmem_ptw_comm_t;

  // Only aligned, physical, doubleword reads can be served by the walker path.
  function automatic logic ptw_read_legal(input logic                phys,
                                          input logic [4:0]          cmd,
                                          input logic [3:0]          typ,
                                          input logic [SIZE_VADDR:0] addr);
    return (cmd == M_XRD) && (typ == MT_D) && (addr[2:0] == 3'b000) && phys;
  endfunction

endpackage

// File: rtl/ptw_mem_bridge_if.sv
// Memory-side read port of the PTW bridge: request/grant plus read-data return.
interface ptw_mem_bridge_if
  import mmu_pkg::*;
();

  logic                mem_req;
  logic [SIZE_VADDR:0] mem_addr;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [63:0]         mem_rdata;
  logic                mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

endinterface

// File: rtl/ptw_mem_bridge.sv
// Single-beat read-only bridge from the page-table walker onto a
// req/gnt/rvalid memory port, with error, kill and timeout handling.
module ptw_mem_bridge
  import mmu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  ptw_dmem_comm_t      ptw_dmem_comm_i,
  output dmem_ptw_comm_t      dmem_ptw_comm_o,
  output logic                mem_req_o,
  output logic [SIZE_VADDR:0] mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [63:0]         mem_rdata_i,
  input  logic                mem_err_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    NACK  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [SIZE_VADDR:0] addr_r, addr_s;
  logic [63:0]         data_r, data_s;
  logic                tmo_s;
  logic                ready_r, valid_r, nack_r, mem_req_r;
  logic                kill_s;
  logic                unused_s;

  assign kill_s   = ptw_dmem_comm_i.req.kill;
  assign unused_s = ^ptw_dmem_comm_i.req.data;

  // Next-state and next-register values; outputs are decoded from the next state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    data_s  = data_r;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ptw_dmem_comm_i.req.valid && ready_r) begin
          addr_s = ptw_dmem_comm_i.req.addr;
          if (ptw_read_legal(ptw_dmem_comm_i.req.phys, ptw_dmem_comm_i.req.cmd,
                             ptw_dmem_comm_i.req.typ, ptw_dmem_comm_i.req.addr)) begin
            state_s = ISSUE;
          end else begin
            state_s = NACK;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // A kill racing the grant leaves a read in flight that must be drained.
        if (kill_s) begin
          state_s = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_s = WAIT;
          cnt_s   = '0;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          if (kill_s) begin
            state_s = IDLE;
          end else if (mem_err_i) begin
            state_s = NACK;
          end else begin
            state_s = RESP;
            data_s  = mem_rdata_i;
          end
        end else if (kill_s) begin
          state_s = DRAIN;
        end else if (cnt_r == CNT_LAST) begin
          state_s = DRAIN;
          tmo_s   = 1'b1;
        end else begin
          state_s = WAIT;
          cnt_s   = (cnt_r != CNT_MAX) ? cnt_r + CNT_W'(1) : cnt_r;
        end
      end
      RESP:    state_s = IDLE;
      NACK:    state_s = IDLE;
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      nack_r    <= 1'b0;
      mem_req_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      ready_r   <= (state_s == IDLE);
      valid_r   <= (state_s == RESP);
      nack_r    <= (state_s == NACK) || tmo_s;
      mem_req_r <= (state_s == ISSUE);
    end
  end

  assign dmem_ptw_comm_o.dmem_ready = ready_r;
  assign dmem_ptw_comm_o.resp.valid = valid_r;
  assign dmem_ptw_comm_o.resp.nack  = nack_r;
  assign dmem_ptw_comm_o.resp.data  = data_r;
  assign mem_req_o                  = mem_req_r;
  assign mem_addr_o                 = addr_r;

endmodule

// File: tb/tb_ptw_mem_bridge.sv
// Randomized self-checking bench for ptw_mem_bridge against a transaction-level
// timing model of the walker read protocol.
module tb_ptw_mem_bridge;
  import mmu_pkg::*;

  localparam int TO = 8;

  logic           clk;
  logic           rstn;
  ptw_dmem_comm_t req_s;
  dmem_ptw_comm_t rsp_s;
  int             checks = 0;
  int             errors = 0;

  ptw_mem_bridge_if bus ();

  ptw_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ptw_dmem_comm_i (req_s),
    .dmem_ptw_comm_o (rsp_s),
    .mem_req_o       (bus.mem_req),
    .mem_addr_o      (bus.mem_addr),
    .mem_gnt_i       (bus.mem_gnt),
    .mem_rvalid_i    (bus.mem_rvalid),
    .mem_rdata_i     (bus.mem_rdata),
    .mem_err_i       (bus.mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(rsp_s.dmem_ready), 64'd0);
    check_eq({tag, "_valid"}, 64'(rsp_s.resp.valid), 64'd0);
    check_eq({tag, "_nack"}, 64'(rsp_s.resp.nack), 64'd0);
    check_eq({tag, "_data"}, rsp_s.resp.data, 64'd0);
    check_eq({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
    check_eq({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
  endtask

  task automatic idle_inputs();
    req_s          = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Called at a falling edge with the bridge idle and ready. g: ISSUE cycles
  // without grant; r: WAIT cycles before rvalid; kmode 1 = kill at ISSUE index k,
  // kmode 2 = kill at WAIT index k.
  task automatic run_txn(input logic phys, input logic [4:0] cmd, input logic [3:0] typ,
                         input logic [SIZE_VADDR:0] addr, input int g, input int r,
                         input logic e, input int kmode, input int k, input logic [63:0] rdata);
    logic legal, granted, rv, noise, tmo;
    int   rc, rsp_cyc, kind, req_end;
    logic [31:0] rnd;
    legal   = (cmd == 5'b00000) && (typ == 4'b0011) && (addr[2:0] == 3'b000) && phys;
    granted = legal && !(kmode == 1 && k < g);
    tmo     = 1'b0;
    kind    = 0;
    rsp_cyc = -1;
    req_end = 0;
    if (!legal) begin
      kind = 2; rsp_cyc = 1; rc = 2;
    end else if (kmode == 1 && k < g) begin
      rc = k + 2; req_end = k + 1;
    end else begin
      req_end = g + 1;
      if (kmode != 0) begin
        rc = g + 3 + r;
      end else if (r >= TO) begin
        kind = 2; rsp_cyc = g + TO + 2; rc = g + 3 + r; tmo = 1'b1;
      end else begin
        kind = e ? 2 : 1; rsp_cyc = g + 3 + r; rc = g + 4 + r;
      end
    end

    req_s.req.valid = 1'b1;
    req_s.req.phys  = phys;
    req_s.req.cmd   = cmd;
    req_s.req.typ   = typ;
    req_s.req.addr  = addr;
    req_s.req.kill  = 1'b0;
    req_s.req.data  = {32'($urandom), 32'($urandom)};
    @(posedge clk);
    for (int n = 1; n <= rc; n++) begin
      @(negedge clk);
      check_eq("ready", 64'(rsp_s.dmem_ready), 64'(n == rc));
      check_eq("valid", 64'(rsp_s.resp.valid), 64'(kind == 1 && n == rsp_cyc));
      check_eq("nack", 64'(rsp_s.resp.nack), 64'(kind == 2 && n == rsp_cyc));
      check_eq("mem_req", 64'(bus.mem_req), 64'(legal && n <= req_end));
      if (legal && n <= req_end) check_eq("mem_addr", 64'(bus.mem_addr), 64'(addr));
      if (kind == 1 && n == rsp_cyc) check_eq("rdata", rsp_s.resp.data, rdata);
      // Junk requests while busy and stray rvalid where it must be ignored.
      rnd             = $urandom;
      req_s.req.valid = (n < rc) ? rnd[0] : 1'b0;
      req_s.req.addr  = {rnd[7:0], rnd, 1'b0, rnd[2:1], 1'b0} & {(SIZE_VADDR+1){1'b1}};
      req_s.req.cmd   = rnd[12:8];
      req_s.req.typ   = rnd[16:13];
      req_s.req.phys  = rnd[17];
      req_s.req.kill  = (kmode == 1 && n == k + 1) || (kmode == 2 && n == g + 2 + k);
      bus.mem_gnt     = granted && (n == g + 1);
      rv              = granted && (n == g + 2 + r);
      noise           = rnd[20] && ((n <= g + 1) || (kind != 0 && !tmo && n == rsp_cyc));
      bus.mem_rvalid  = rv || noise;
      bus.mem_err     = rv ? e : rnd[21];
      bus.mem_rdata   = rv ? rdata : {32'($urandom), rnd};
    end
    idle_inputs();
  endtask

  task automatic reset_in_wait();
    req_s.req.valid = 1'b1;
    req_s.req.phys  = 1'b1;
    req_s.req.cmd   = M_XRD;
    req_s.req.typ   = MT_D;
    req_s.req.addr  = 40'h00_8000_2000;
    @(posedge clk);
    @(negedge clk);
    req_s.req.valid = 1'b0;
    bus.mem_gnt     = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check_eq("rst_wait_mem_req", 64'(bus.mem_req), 64'd0);
    #1 rstn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rstn           = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check_eq("rst_late_ready", 64'(rsp_s.dmem_ready), 64'd1);
    check_eq("rst_late_valid", 64'(rsp_s.resp.valid), 64'd0);
    check_eq("rst_late_nack", 64'(rsp_s.resp.nack), 64'd0);
    @(negedge clk);
    check_eq("rst_late_valid2", 64'(rsp_s.resp.valid), 64'd0);
    check_eq("rst_late_nack2", 64'(rsp_s.resp.nack), 64'd0);
    check_eq("rst_late_ready2", 64'(rsp_s.dmem_ready), 64'd1);
  endtask

  initial begin
    logic                phys;
    logic [4:0]          cmd;
    logic [3:0]          typ;
    logic [SIZE_VADDR:0] addr;
    logic [31:0]         a0, a1;
    int                  g, r, km, k, sel;
    logic                e;

    rstn = 1'b0;
    idle_inputs();
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1 check_eq("ready_before_edge", 64'(rsp_s.dmem_ready), 64'd0);
    @(negedge clk);
    check_eq("ready_after_reset", 64'(rsp_s.dmem_ready), 64'd1);

    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1000, 0, 0, 1'b0, 0, 0, 64'h0000_0000_2000_0401);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1004, 0, 0, 1'b0, 0, 0, 64'd0);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1008, 5, 0, 1'b1, 0, 0, 64'h1234);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1010, 0, TO + 3, 1'b0, 0, 0, 64'h5678);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1018, 1, 4, 1'b0, 2, 0, 64'h9ABC);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1020, 2, TO - 1, 1'b0, 0, 0, 64'hCAFE);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1028, 3, 2, 1'b0, 1, 1, 64'd0);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1030, 2, 3, 1'b0, 1, 2, 64'd0);
    run_txn(1'b1, M_XRD, MT_D, 40'h00_8000_1038, 0, 3, 1'b0, 2, 3, 64'd0);
    reset_in_wait();

    for (int t = 0; t < 60; t++) begin
      a0   = $urandom;
      a1   = $urandom;
      phys = 1'b1;
      cmd  = M_XRD;
      typ  = MT_D;
      addr = {a0[7:0], a1[31:3], 3'b000};
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       phys = 1'b0;
        1:       cmd = 5'($urandom_range(1, 31));
        2:       typ = (a0[11:8] == 4'b0011) ? 4'b0111 : a0[11:8];
        3:       addr[2:0] = 3'($urandom_range(1, 7));
        default: ;
      endcase
      g  = $urandom_range(0, 4);
      r  = $urandom_range(0, TO + 2);
      e  = ($urandom_range(0, 3) == 0);
      km = $urandom_range(0, 5);
      km = (km == 0) ? 1 : (km == 1) ? 2 : 0;
      if (km == 1) k = $urandom_range(0, g);
      else if (km == 2) k = $urandom_range(0, (r < TO - 1) ? r : TO - 1);
      else k = 0;
      run_txn(phys, cmd, typ, addr, g, r, e, km, k, {a1, a0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_mem_bridge.md
PTW_MEM_BRIDGE -- requirements
Module: ptw_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before a request is abandoned with nack.
REQ-002 SHALL have port clk_i, input, 1 bit: clock.
REQ-003 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port ptw_dmem_comm_i, input, ptw_dmem_comm_t: PTW request (req.valid/phys/cmd/typ/addr/kill/data).
REQ-005 SHALL have port dmem_ptw_comm_o, output, dmem_ptw_comm_t: dmem_ready, resp.valid, resp.nack, resp.data[63:0].
REQ-006 SHALL have port mem_req_o, output, 1 bit: memory read request, held until granted.
REQ-007 SHALL have port mem_addr_o, output, SIZE_VADDR+1 bits: physical read address.
REQ-008 SHALL have port mem_gnt_i, input, 1 bit: memory accepts the request this cycle.
REQ-009 SHALL have port mem_rvalid_i, input, 1 bit: read data valid.
REQ-010 SHALL have port mem_rdata_i, input, 64 bits: read data.
REQ-011 SHALL have port mem_err_i, input, 1 bit: bus error, qualified by mem_rvalid_i.

Function
REQ-012 FSM SHALL have the states IDLE, ISSUE, WAIT, RESP, NACK and DRAIN.
REQ-013 dmem_ready SHALL be 1 only in IDLE; a request is accepted when req.valid && dmem_ready, and addr, cmd and typ SHALL be registered at acceptance.
REQ-014 On acceptance, if cmd != M_XRD (5'b00000), or typ != MT_D (4'b0011), or addr[2:0] != 0, or phys == 0, the FSM SHALL go IDLE->NACK; otherwise it SHALL go IDLE->ISSUE.
REQ-015 In ISSUE, mem_req_o SHALL be 1 with mem_addr_o equal to the registered addr; on mem_gnt_i the FSM SHALL go to WAIT and clear the timeout counter.
REQ-016 In WAIT, the timeout counter SHALL increment each cycle without mem_rvalid_i.
- mem_rvalid_i && !mem_err_i: capture mem_rdata_i and go to RESP.
- mem_rvalid_i && mem_err_i: go to NACK.
- Counter == TIMEOUT_CYCLES-1 without rvalid: go to DRAIN and pulse resp.nack in the same cycle.
REQ-017 RESP SHALL last exactly 1 cycle with resp.valid=1, nack=0 and resp.data equal to the captured word, then return to IDLE.
REQ-018 NACK SHALL last exactly 1 cycle with resp.nack=1, valid=0, then return to IDLE.
REQ-019 DRAIN SHALL hold dmem_ready=0 and mem_req_o=0, and on mem_rvalid_i SHALL discard the data and go to IDLE with no response.
REQ-020 Minimum latency SHALL be 3 cycles from acceptance to resp.valid (gnt in the first ISSUE cycle, rvalid 1 cycle later).
REQ-021 resp.valid and resp.nack SHALL never both be 1, and each SHALL be a 1-cycle pulse.
REQ-022 Kill handling SHALL be as follows, with no response produced in any case:
- req.kill=1 in ISSUE before gnt: go to IDLE; mem_req_o drops next cycle.
- req.kill=1 in ISSUE with gnt in the same cycle, or in WAIT: go to DRAIN.
- Kill in WAIT together with mem_rvalid_i: go to IDLE.
REQ-023 req.valid SHALL be ignored outside IDLE.
REQ-024 mem_rvalid_i outside WAIT and DRAIN SHALL be ignored.
REQ-025 The request data field SHALL be unused (read-only bridge).
REQ-026 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1), and the counter SHALL saturate, never wrap.

Reset
REQ-027 Asynchronous assertion of rstn_i SHALL force IDLE with timeout counter 0 and captured data 0.
REQ-028 While in reset, outputs SHALL be: dmem_ready=0, resp.valid=0, resp.nack=0, resp.data=0, mem_req_o=0, mem_addr_o=0.
REQ-029 dmem_ready SHALL rise in the first cycle after deassertion.
REQ-030 Reset asserted mid-transaction SHALL drop that transaction without any response, and a late mem_rvalid_i after reset SHALL be ignored.

Structure
REQ-031 M_XRD, MT_D, ptw_dmem_comm_t, dmem_ptw_comm_t and SIZE_VADDR SHALL come from mmu_pkg; M_XRD and MT_D SHALL move there from local definitions.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Legal read: addr=0x80001000, gnt in the first ISSUE cycle, rvalid 1 cycle later with rdata=0x0000_0000_2000_0401 -> resp.valid=1 for 1 cycle with data=0x2000_0401, 3 cycles after acceptance, then dmem_ready=1.
REQ-035 Misaligned read: addr=0x80001004 -> resp.nack=1 in the cycle after acceptance, mem_req_o never 1.
REQ-036 Grant backpressure then error: gnt withheld for 5 cycles (mem_req_o stays 1, addr stable), then rvalid with mem_err_i=1 -> single nack, no valid.
REQ-037 Timeout: TIMEOUT_CYCLES=8, no rvalid after gnt -> nack pulse after 8 WAIT cycles, dmem_ready=0 until a later rvalid, then IDLE with no response.
REQ-038 Kill in WAIT, then rvalid 4 cycles later -> no valid/nack, dmem_ready returns the cycle after rvalid.
REQ-039 Reset asserted in WAIT, then rvalid after deassertion -> no response, dmem_ready=1 the first cycle after deassertion.
